// File: rtl/inst_fetch_if.sv
// Instruction-fetch responder: translates the PC, runs one outstanding SRAM-like
// bus transaction at a time and holds the returned word for decode.
module inst_fetch_if #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] pc,
  input  logic             stallD,
  input  logic             flush,
  output logic             i_stall,
  output logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] inst_pc,
  output logic             inst_valid,
  output logic             adel,
  output logic             inst_req,
  output logic [WIDTH-1:0] inst_addr,
  input  logic             inst_addr_ok,
  input  logic             inst_data_ok,
  input  logic [WIDTH-1:0] inst_rdata
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       r_state;
  logic             r_cancel;
  logic [WIDTH-1:0] r_inst;
  logic [WIDTH-1:0] r_inst_pc;
  logic             r_adel;
  logic [WIDTH-1:0] r_addr;

  logic [WIDTH-1:0] w_paddr;
  logic             w_idle_go;
  logic             w_issue;
  logic             w_misalign;

  // kseg0/kseg1 (pc[31:29] = 100/101) are unmapped: strip the top three bits.
  always_comb begin
    w_paddr = pc;
    if (pc[WIDTH-1 -: 2] == 2'b10) w_paddr[WIDTH-1 -: 3] = 3'b000;
  end

  assign w_idle_go  = (r_state == S_IDLE) & ce & ~flush & ~r_cancel;
  assign w_issue    = w_idle_go & (pc[1:0] == 2'b00);
  assign w_misalign = w_idle_go & (pc[1:0] != 2'b00);

  assign inst_req   = ~rst & (w_issue | (r_state == S_ADDR));
  assign inst_addr  = (r_state == S_ADDR) ? r_addr : w_paddr;
  assign i_stall    = ce & (r_state != S_DONE) & ~flush;
  assign inst_valid = (r_state == S_DONE);
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign adel       = r_adel;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cancel  <= 1'b0;
      r_inst    <= '0;
      r_inst_pc <= '0;
      r_adel    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_inst_pc <= pc;
            r_addr    <= w_paddr;
            r_state   <= inst_addr_ok ? S_DATA : S_ADDR;
          end else if (w_misalign) begin
            r_inst    <= '0;
            r_adel    <= 1'b1;
            r_inst_pc <= pc;
            r_state   <= S_DONE;
          end
        end
        // The request cannot be withdrawn; a flush only marks the data stale.
        S_ADDR: begin
          if (flush) r_cancel <= 1'b1;
          if (inst_addr_ok) r_state <= S_DATA;
        end
        S_DATA: begin
          if (inst_data_ok) begin
            if (r_cancel | flush) begin
              r_cancel <= 1'b0;
              r_state  <= S_IDLE;
            end else begin
              r_inst  <= inst_rdata;
              r_adel  <= 1'b0;
              r_state <= S_DONE;
            end
          end else if (flush) begin
            r_cancel <= 1'b1;
          end
        end
        S_DONE: begin
          if (!stallD || flush) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_fetch_if.sv
// Bench for inst_fetch_if: directed bring-up sequence, then randomized fetches
// against a transaction-level model with a scoreboard and a random-latency bus.
module tb_inst_fetch_if;
  logic        clk;
  logic        rst, ce, stallD, flush;
  logic [31:0] pc;
  logic        i_stall, inst_valid, adel, inst_req;
  logic [31:0] inst, inst_pc, inst_addr, inst_rdata;
  logic        inst_addr_ok, inst_data_ok;

  logic        auto_bus;
  logic        d_aok, d_dok;
  logic [31:0] d_rdata;
  logic        a_aok, a_dok;
  logic [31:0] a_rdata;

  int checks = 0;
  int errors = 0;
  bit aborted = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        adel;
  } exp_t;
  exp_t exp_q[$];

  logic        bus_pending, bus_await, bus_inflight;
  logic [31:0] exp_addr, pend_word;
  logic [31:0] p;
  bit          got;
  int          hold, dly;

  assign inst_addr_ok = auto_bus ? a_aok   : d_aok;
  assign inst_data_ok = auto_bus ? a_dok   : d_dok;
  assign inst_rdata   = auto_bus ? a_rdata : d_rdata;

  inst_fetch_if #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .ce(ce), .pc(pc), .stallD(stallD), .flush(flush),
    .i_stall(i_stall), .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .adel(adel), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] xlate(input logic [31:0] a);
    return (a[31:30] == 2'b10) ? {3'b000, a[28:0]} : a;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ {a[15:0], a[31:16]} ^ 32'h13579bdf;
  endfunction

  function automatic logic [31:0] rand_pc(input bit allow_mis);
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: r[31:29] = 3'b100;
      1: r[31:29] = 3'b101;
      default: ;
    endcase
    if (!allow_mis || $urandom_range(0, 7) != 0) r[1:0] = 2'b00;
    return r;
  endfunction

  task automatic push(input logic [31:0] w, input logic [31:0] a, input logic e);
    exp_t x;
    x.inst = w;
    x.pc   = a;
    x.adel = e;
    exp_q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: each new instruction pops one expectation; a held one must not move.
  initial begin : monitor
    logic        m_prev;
    logic [31:0] h_inst, h_pc;
    logic        h_adel;
    exp_t        e;
    m_prev = 1'b0;
    h_inst = '0;
    h_pc   = '0;
    h_adel = 1'b0;
    forever begin
      @(negedge clk);
      if (inst_valid === 1'b1 && !m_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", {31'b0, inst_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("mon_inst", inst, e.inst);
          check("mon_inst_pc", inst_pc, e.pc);
          check("mon_adel", {31'b0, adel}, {31'b0, e.adel});
        end
        h_inst = inst;
        h_pc   = inst_pc;
        h_adel = adel;
      end else if (inst_valid === 1'b1 && m_prev) begin
        check("hold_inst", inst, h_inst);
        check("hold_inst_pc", inst_pc, h_pc);
        check("hold_adel", {31'b0, adel}, {31'b0, h_adel});
      end
      m_prev = (inst_valid === 1'b1);
    end
  end

  // Random-latency bus slave; also checks the request address against the translated PC.
  initial begin : bus
    bus_pending = 0; bus_await = 0; bus_inflight = 0;
    a_aok = 0; a_dok = 0; a_rdata = '0; exp_addr = '0; pend_word = '0;
    forever begin
      @(negedge clk);
      if (rst || !auto_bus) begin
        bus_pending = 0;
        bus_await   = 0;
      end else begin
        if (inst_req) begin
          if (!bus_await) exp_addr = xlate(pc);
          check("bus_inst_addr", inst_addr, exp_addr);
        end
        if (bus_pending) begin
          if (a_dok) bus_pending = 0;
        end else if (inst_req && a_aok) begin
          bus_pending = 1;
          pend_word   = mem_word(exp_addr);
        end
        bus_await = inst_req && !a_aok;
      end
      bus_inflight = bus_pending || bus_await;
      @(posedge clk);
      #1;
      a_aok = ($urandom_range(0, 2) != 0);
      if (bus_pending) begin
        a_dok   = ($urandom_range(0, 1) != 0);
        a_rdata = a_dok ? pend_word : $urandom;
      end else begin
        a_dok   = ($urandom_range(0, 7) == 0);
        a_rdata = $urandom;
      end
    end
  end

  initial begin : main
    auto_bus = 0; rst = 1; ce = 0; pc = '0; stallD = 0; flush = 0;
    d_aok = 0; d_dok = 0; d_rdata = '0;
    tick(); tick();
    @(negedge clk);
    check("rst_req", {31'b0, inst_req}, 32'd0);
    check("rst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_adel", {31'b0, adel}, 32'd0);

    tick(); rst = 0; ce = 0; pc = 32'hbfc00000;
    @(negedge clk);
    check("ce0_req", {31'b0, inst_req}, 32'd0);
    check("ce0_stall", {31'b0, i_stall}, 32'd0);

    // Zero-wait fetch: request in the cycle ce rises.
    tick(); ce = 1; d_aok = 1;
    @(negedge clk);
    check("zw_req", {31'b0, inst_req}, 32'd1);
    check("zw_addr", inst_addr, 32'h1fc00000);
    check("zw_stall0", {31'b0, i_stall}, 32'd1);
    push(32'h3c1dbfc0, 32'hbfc00000, 1'b0);
    tick(); d_aok = 0; d_dok = 1; d_rdata = 32'h3c1dbfc0;
    @(negedge clk);
    check("zw_stall1", {31'b0, i_stall}, 32'd1);
    check("zw_valid1", {31'b0, inst_valid}, 32'd0);
    tick(); d_dok = 0; stallD = 1; pc = 32'hbfc00004;
    @(negedge clk);
    check("zw_valid2", {31'b0, inst_valid}, 32'd1);
    check("zw_stall2", {31'b0, i_stall}, 32'd0);
    check("done_req", {31'b0, inst_req}, 32'd0);

    // Decode stall holds the instruction.
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      check("stallD_valid", {31'b0, inst_valid}, 32'd1);
    end
    tick(); stallD = 0;
    @(negedge clk);
    check("release_valid", {31'b0, inst_valid}, 32'd1);

    // Wait states: addr_ok after 3 cycles, data_ok after 2 more.
    tick(); d_aok = 0;
    @(negedge clk);
    check("ws_req0", {31'b0, inst_req}, 32'd1);
    check("ws_addr0", inst_addr, 32'h1fc00004);
    check("ws_valid0", {31'b0, inst_valid}, 32'd0);
    push(32'h8c080000, 32'hbfc00004, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick(); pc = $urandom;
      @(negedge clk);
      check("ws_req_held", {31'b0, inst_req}, 32'd1);
      check("ws_addr_held", inst_addr, 32'h1fc00004);
      check("ws_stall", {31'b0, i_stall}, 32'd1);
    end
    tick(); pc = 32'hbfc00004; d_aok = 1;
    @(negedge clk);
    check("ws_addr_acc", inst_addr, 32'h1fc00004);
    for (int i = 0; i < 3; i++) begin
      tick(); d_aok = 0; d_dok = (i == 2); d_rdata = (i == 2) ? 32'h8c080000 : 32'hffffffff;
      @(negedge clk);
      check("ws_data_stall", {31'b0, i_stall}, 32'd1);
      check("ws_data_valid", {31'b0, inst_valid}, 32'd0);
    end
    tick(); d_dok = 0;
    @(negedge clk);
    check("ws_valid7", {31'b0, inst_valid}, 32'd1);

    // Flush in DATA: stale data dropped, redirect fetched afterwards.
    tick(); pc = 32'h80000000; d_aok = 1;
    @(negedge clk);
    check("fl_req", {31'b0, inst_req}, 32'd1);
    check("fl_addr", inst_addr, 32'h00000000);
    tick(); d_aok = 0; flush = 1; pc = 32'h80001000;
    @(negedge clk);
    check("fl_stall", {31'b0, i_stall}, 32'd0);
    tick(); flush = 0; d_dok = 1; d_rdata = 32'hdeadbeef;
    @(negedge clk);
    check("fl_req_data", {31'b0, inst_req}, 32'd0);
    check("fl_valid", {31'b0, inst_valid}, 32'd0);
    tick(); d_dok = 0; d_aok = 1;
    @(negedge clk);
    check("fl_valid_after", {31'b0, inst_valid}, 32'd0);
    check("redir_req", {31'b0, inst_req}, 32'd1);
    check("redir_addr", inst_addr, 32'h00001000);
    push(32'h24080001, 32'h80001000, 1'b0);
    tick(); d_aok = 0; d_dok = 1; d_rdata = 32'h24080001;
    tick(); d_dok = 0;
    @(negedge clk);
    check("redir_valid", {31'b0, inst_valid}, 32'd1);

    // Misaligned PC: no bus request, address error next cycle.
    tick(); pc = 32'hbfc00002;
    @(negedge clk);
    check("mis_req", {31'b0, inst_req}, 32'd0);
    check("mis_stall", {31'b0, i_stall}, 32'd1);
    push(32'h0, 32'hbfc00002, 1'b1);
    tick();
    @(negedge clk);
    check("mis_valid", {31'b0, inst_valid}, 32'd1);

    // Reset while waiting for addr_ok, then a clean fetch of a user address.
    tick(); pc = 32'h00400000; d_aok = 0;
    @(negedge clk);
    check("user_addr", inst_addr, 32'h00400000);
    tick(); rst = 1;
    @(negedge clk);
    check("rstmid_req", {31'b0, inst_req}, 32'd0);
    tick();
    tick(); rst = 0; d_aok = 1;
    @(negedge clk);
    check("post_rst_req", {31'b0, inst_req}, 32'd1);
    check("post_rst_valid", {31'b0, inst_valid}, 32'd0);
    push(32'h3c080040, 32'h00400000, 1'b0);
    tick(); d_aok = 0; d_dok = 1; d_rdata = 32'h3c080040;
    tick(); d_dok = 0; ce = 0;
    @(negedge clk);
    check("post_rst_valid2", {31'b0, inst_valid}, 32'd1);

    // Randomized phase.
    tick(); rst = 1;
    tick(); tick(); rst = 0; auto_bus = 1;
    for (int k = 0; k < 300 && !aborted; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        ce = 0; pc = $urandom; flush = 0; stallD = 0;
        @(negedge clk);
        check("gap_req", {31'b0, inst_req}, 32'd0);
        check("gap_stall", {31'b0, i_stall}, 32'd0);
        tick();
      end
      p = rand_pc(1'b1);
      ce = 1; pc = p; flush = 0; stallD = 0;
      if (p[1:0] != 2'b00) push(32'h0, p, 1'b1);
      else                 push(mem_word(xlate(p)), p, 1'b0);
      if (p[1:0] == 2'b00 && $urandom_range(0, 2) == 0) begin
        tick();
        dly = $urandom_range(0, 2);
        for (int j = 0; j < dly && bus_inflight; j++) tick();
        if (bus_inflight) begin
          void'(exp_q.pop_back());
          p = rand_pc(1'b0);
          pc = p; flush = 1;
          push(mem_word(xlate(p)), p, 1'b0);
          tick(); flush = 0;
        end
      end
      got = 0;
      for (int t = 0; t < 200; t++) begin
        @(negedge clk);
        if (inst_valid === 1'b1) begin
          got = 1;
          break;
        end
        tick();
      end
      if (!got) begin
        check("valid_timeout", 32'd0, 32'd1);
        aborted = 1;
      end else begin
        #1;
        hold = $urandom_range(0, 3);
        stallD = (hold != 0);
        for (int i = 1; i <= hold; i++) begin
          tick();
          stallD = (i < hold);
        end
        if ($urandom_range(0, 4) == 0) flush = 1;
        tick();
        flush = 0; stallD = 0;
      end
    end
    ce = 0;
    tick(); tick();
    check("sb_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
